// File: rtl/bus_pkg.sv
// Shared types and sizing for the CPU-side Wishbone master.
package bus_pkg;

  localparam int ADDR_W          = 32;
  localparam int DATA_W          = 32;
  localparam int SEL_W           = 4;
  localparam int DEFAULT_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    BUSY         = 2'd1,
    WAIT_RELEASE = 2'd2
  } bus_state_t;

  // One latched memory-stage request, as driven onto the bus.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [SEL_W-1:0]  sel;
    logic              we;
  } wb_req_t;

endpackage

// File: rtl/bus_timeout_counter.sv
// 8-bit saturating cycle counter with synchronous clear and a terminal-count flag.
module bus_timeout_counter #(
  parameter int TERMINAL = 254
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_terminal
);

  localparam logic [7:0] TERM_VAL = 8'(TERMINAL);

  logic [7:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= 8'd0;
    end else if (i_en && (r_count != 8'hFF)) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign o_terminal = (r_count == TERM_VAL);

endmodule

// File: rtl/mem_bus_master.sv
// Memory-stage to Wishbone classic-cycle master: stalls the pipeline until ack,
// buffers read data across downstream stalls, aborts on timeout.
module mem_bus_master
  import bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_ce_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [SEL_W-1:0]  cpu_sel_i,
  input  logic [DATA_W-1:0] cpu_data_i,
  output logic [DATA_W-1:0] cpu_data_o,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              stall_req_o,
  output logic              bus_err_o,
  output logic [ADDR_W-1:0] wishbone_addr_o,
  output logic [DATA_W-1:0] wishbone_data_o,
  output logic              wishbone_we_o,
  output logic [SEL_W-1:0]  wishbone_sel_o,
  output logic              wishbone_stb_o,
  output logic              wishbone_cyc_o,
  input  logic [DATA_W-1:0] wishbone_data_i,
  input  logic              wishbone_ack_i
);

  bus_state_t        r_state;
  bus_state_t        w_next_state;
  wb_req_t           r_req;
  logic              r_cyc;
  logic              r_stb;
  logic [DATA_W-1:0] r_rd_buf;
  logic              r_bus_err;

  logic w_accept;
  logic w_ack;
  logic w_timeout;
  logic w_cnt_en;
  logic w_terminal;

  bus_timeout_counter #(
    .TERMINAL (TIMEOUT_CYCLES - 1)
  ) u_timeout (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_accept),
    .i_en       (w_cnt_en),
    .o_terminal (w_terminal)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Flush overrides every state; WAIT_RELEASE keeps the held instruction from reissuing.
  always_comb begin
    // NOTE: combinational blocks assign a default first so no path can infer a latch.
    w_next_state = r_state;
    if (flush_i) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE:         if (cpu_ce_i) w_next_state = BUSY;
        BUSY: begin
          if (wishbone_ack_i)  w_next_state = stall_i ? WAIT_RELEASE : IDLE;
          else if (w_terminal) w_next_state = IDLE;
        end
        WAIT_RELEASE: if (!stall_i) w_next_state = IDLE;
        default:      w_next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    w_accept    = (r_state == IDLE) && cpu_ce_i && !flush_i;
    w_ack       = (r_state == BUSY) && wishbone_ack_i && !flush_i;
    w_timeout   = (r_state == BUSY) && !wishbone_ack_i && w_terminal && !flush_i;
    w_cnt_en    = (r_state == BUSY) && !wishbone_ack_i && !w_terminal && !flush_i;
    stall_req_o = w_accept || ((r_state == BUSY) && !flush_i && !wishbone_ack_i && !w_terminal);
    cpu_data_o  = ((r_state == BUSY) && wishbone_ack_i) ? wishbone_data_i : r_rd_buf;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req     <= '0;
      r_cyc     <= 1'b0;
      r_stb     <= 1'b0;
      r_rd_buf  <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_bus_err <= w_timeout;
      if (w_accept) begin
        r_req <= '{addr: cpu_addr_i, data: cpu_data_i, sel: cpu_sel_i, we: cpu_we_i};
        r_cyc <= 1'b1;
        r_stb <= 1'b1;
      end else if (flush_i) begin
        r_cyc <= 1'b0;
        r_stb <= 1'b0;
      end else if (w_ack) begin
        r_cyc    <= 1'b0;
        r_stb    <= 1'b0;
        r_req.we <= 1'b0;
        r_rd_buf <= r_req.we ? '0 : wishbone_data_i;
      end else if (w_timeout) begin
        r_cyc    <= 1'b0;
        r_stb    <= 1'b0;
        r_rd_buf <= '0;
      end
    end
  end

  assign wishbone_addr_o = r_req.addr;
  assign wishbone_data_o = r_req.data;
  assign wishbone_sel_o  = r_req.sel;
  assign wishbone_we_o   = r_req.we;
  assign wishbone_cyc_o  = r_cyc;
  assign wishbone_stb_o  = r_stb;
  assign bus_err_o       = r_bus_err;

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench for mem_bus_master with an 8-cycle timeout.
module tb_mem_bus_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_ce_i = 1'b0;
  logic        cpu_we_i = 1'b0;
  logic [31:0] cpu_addr_i = '0;
  logic [3:0]  cpu_sel_i = '0;
  logic [31:0] cpu_data_i = '0;
  logic [31:0] cpu_data_o;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        stall_req_o;
  logic        bus_err_o;
  logic [31:0] wishbone_addr_o;
  logic [31:0] wishbone_data_o;
  logic        wishbone_we_o;
  logic [3:0]  wishbone_sel_o;
  logic        wishbone_stb_o;
  logic        wishbone_cyc_o;
  logic [31:0] wishbone_data_i = '0;
  logic        wishbone_ack_i = 1'b0;

  int checks = 0;
  int failures = 0;

  mem_bus_master #(.TIMEOUT_CYCLES(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .cpu_ce_i        (cpu_ce_i),
    .cpu_we_i        (cpu_we_i),
    .cpu_addr_i      (cpu_addr_i),
    .cpu_sel_i       (cpu_sel_i),
    .cpu_data_i      (cpu_data_i),
    .cpu_data_o      (cpu_data_o),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .stall_req_o     (stall_req_o),
    .bus_err_o       (bus_err_o),
    .wishbone_addr_o (wishbone_addr_o),
    .wishbone_data_o (wishbone_data_o),
    .wishbone_we_o   (wishbone_we_o),
    .wishbone_sel_o  (wishbone_sel_o),
    .wishbone_stb_o  (wishbone_stb_o),
    .wishbone_cyc_o  (wishbone_cyc_o),
    .wishbone_data_i (wishbone_data_i),
    .wishbone_ack_i  (wishbone_ack_i)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Start a new cycle: inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling, well before the next edge.
  task automatic settle();
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    settle();
    checks++;
    if ({wishbone_cyc_o, wishbone_stb_o, wishbone_we_o, stall_req_o, bus_err_o} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=00000",
               {wishbone_cyc_o, wishbone_stb_o, wishbone_we_o, stall_req_o, bus_err_o});
    end
    checks++;
    if ({wishbone_addr_o, wishbone_data_o, wishbone_sel_o, cpu_data_o} !== 100'd0) begin
      failures++;
      $display("FAIL reset_data addr=%h data=%h sel=%h rd=%h exp all zero",
               wishbone_addr_o, wishbone_data_o, wishbone_sel_o, cpu_data_o);
    end
    rst = 1'b0;
  endtask

  task automatic test_read();
    step();  // cycle 0
    cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0010; cpu_sel_i = 4'hF;
    settle();
    checks++;
    if ({stall_req_o, wishbone_cyc_o} !== 2'b10) begin
      failures++;
      $display("FAIL read_c0 stall/cyc got=%b exp=10", {stall_req_o, wishbone_cyc_o});
    end
    step();  // cycle 1
    settle();
    checks++;
    if ({wishbone_cyc_o, wishbone_stb_o, wishbone_we_o, stall_req_o} !== 4'b1101 ||
        wishbone_addr_o !== 32'h0000_0010) begin
      failures++;
      $display("FAIL read_c1 cyc/stb/we/stall got=%b addr=%h exp=1101 addr=00000010",
               {wishbone_cyc_o, wishbone_stb_o, wishbone_we_o, stall_req_o}, wishbone_addr_o);
    end
    step();  // cycle 2
    settle();
    checks++;
    if (stall_req_o !== 1'b1) begin
      failures++;
      $display("FAIL read_c2 stall got=%b exp=1", stall_req_o);
    end
    step();  // cycle 3: ack
    wishbone_ack_i = 1'b1; wishbone_data_i = 32'hDEAD_BEEF;
    settle();
    checks++;
    if (stall_req_o !== 1'b0 || cpu_data_o !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL read_c3 stall=%b data=%h exp stall=0 data=deadbeef", stall_req_o, cpu_data_o);
    end
    step();  // cycle 4
    wishbone_ack_i = 1'b0; wishbone_data_i = 32'h0; cpu_ce_i = 1'b0;
    settle();
    checks++;
    if (wishbone_cyc_o !== 1'b0 || stall_req_o !== 1'b0 || cpu_data_o !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL read_c4 cyc=%b stall=%b data=%h exp cyc=0 stall=0 data=deadbeef",
               wishbone_cyc_o, stall_req_o, cpu_data_o);
    end
  endtask

  task automatic test_write();
    step();  // cycle 0
    cpu_ce_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h0000_0020;
    cpu_data_i = 32'h1234_5678; cpu_sel_i = 4'b0011;
    settle();
    checks++;
    if (stall_req_o !== 1'b1) begin
      failures++;
      $display("FAIL write_c0 stall got=%b exp=1", stall_req_o);
    end
    step();  // cycle 1: ack
    wishbone_ack_i = 1'b1;
    settle();
    checks++;
    if (wishbone_addr_o !== 32'h0000_0020 || wishbone_data_o !== 32'h1234_5678 ||
        wishbone_sel_o !== 4'b0011 || {wishbone_we_o, wishbone_cyc_o, wishbone_stb_o} !== 3'b111) begin
      failures++;
      $display("FAIL write_bus addr=%h data=%h sel=%b we/cyc/stb=%b exp 00000020 12345678 0011 111",
               wishbone_addr_o, wishbone_data_o, wishbone_sel_o,
               {wishbone_we_o, wishbone_cyc_o, wishbone_stb_o});
    end
    checks++;
    if (stall_req_o !== 1'b0) begin
      failures++;
      $display("FAIL write_ack_stall got=%b exp=0", stall_req_o);
    end
    step();  // cycle 2
    wishbone_ack_i = 1'b0; cpu_ce_i = 1'b0; cpu_we_i = 1'b0;
    settle();
    checks++;
    if ({wishbone_cyc_o, wishbone_we_o} !== 2'b00 || cpu_data_o !== 32'h0) begin
      failures++;
      $display("FAIL write_done cyc/we=%b rd=%h exp cyc/we=00 rd=00000000",
               {wishbone_cyc_o, wishbone_we_o}, cpu_data_o);
    end
  endtask

  task automatic test_stall_hold();
    int cyc_cycles = 0;
    step();  // cycle 0
    cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0040; cpu_sel_i = 4'hF;
    settle();
    for (int c = 1; c <= 6; c++) begin
      step();
      stall_i         = (c >= 1 && c <= 4);
      wishbone_ack_i  = (c == 1);
      wishbone_data_i = (c == 1) ? 32'hCAFE_F00D : 32'h0BAD_BAD0;
      cpu_ce_i        = (c <= 5);
      settle();
      if (wishbone_cyc_o === 1'b1) cyc_cycles++;
      if (c >= 1 && c <= 5) begin
        checks++;
        if (cpu_data_o !== 32'hCAFE_F00D || stall_req_o !== 1'b0) begin
          failures++;
          $display("FAIL stall_hold_c%0d rd=%h stall=%b exp rd=cafef00d stall=0",
                   c, cpu_data_o, stall_req_o);
        end
      end
    end
    wishbone_data_i = 32'h0;
    checks++;
    if (cyc_cycles !== 1) begin
      failures++;
      $display("FAIL stall_hold_cyc_count got=%0d exp=1", cyc_cycles);
    end
  endtask

  task automatic test_timeout();
    int cyc_cycles = 0;
    int err_cycles = 0;
    step();  // cycle 0
    cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0080;
    settle();
    for (int c = 1; c <= 12; c++) begin
      step();
      cpu_ce_i = (c <= 8);
      settle();
      if (wishbone_cyc_o === 1'b1) cyc_cycles++;
      if (bus_err_o === 1'b1) err_cycles++;
      if (c == 7 || c == 8) begin
        checks++;
        if (stall_req_o !== (c == 7)) begin
          failures++;
          $display("FAIL timeout_stall_c%0d got=%b exp=%b", c, stall_req_o, (c == 7));
        end
      end
      if (c == 9) begin
        checks++;
        if (bus_err_o !== 1'b1 || wishbone_cyc_o !== 1'b0) begin
          failures++;
          $display("FAIL timeout_err_c9 err=%b cyc=%b exp err=1 cyc=0", bus_err_o, wishbone_cyc_o);
        end
      end
    end
    checks++;
    if (cyc_cycles !== 8 || err_cycles !== 1) begin
      failures++;
      $display("FAIL timeout_counts cyc=%0d err=%0d exp cyc=8 err=1", cyc_cycles, err_cycles);
    end
    checks++;
    if (cpu_data_o !== 32'h0) begin
      failures++;
      $display("FAIL timeout_rd got=%h exp=00000000", cpu_data_o);
    end
  endtask

  task automatic test_flush();
    int err_cycles = 0;
    step();  // cycle 0
    cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0100;
    settle();
    step();  // cycle 1: BUSY
    step();  // cycle 2: BUSY, flushed
    flush_i = 1'b1;
    settle();
    checks++;
    if (stall_req_o !== 1'b0 || wishbone_cyc_o !== 1'b1) begin
      failures++;
      $display("FAIL flush_c2 stall=%b cyc=%b exp stall=0 cyc=1", stall_req_o, wishbone_cyc_o);
    end
    step();  // cycle 3: late ack
    flush_i = 1'b0; cpu_ce_i = 1'b0;
    wishbone_ack_i = 1'b1; wishbone_data_i = 32'h55AA_55AA;
    settle();
    checks++;
    if (wishbone_cyc_o !== 1'b0 || cpu_data_o !== 32'h0 || stall_req_o !== 1'b0) begin
      failures++;
      $display("FAIL flush_c3 cyc=%b rd=%h stall=%b exp cyc=0 rd=00000000 stall=0",
               wishbone_cyc_o, cpu_data_o, stall_req_o);
    end
    for (int c = 4; c <= 14; c++) begin
      step();
      wishbone_ack_i = 1'b0; wishbone_data_i = 32'h0;
      settle();
      if (bus_err_o === 1'b1 || wishbone_cyc_o === 1'b1) err_cycles++;
    end
    checks++;
    if (err_cycles !== 0 || cpu_data_o !== 32'h0) begin
      failures++;
      $display("FAIL flush_after err_or_cyc_cycles=%0d rd=%h exp 0 and 00000000", err_cycles, cpu_data_o);
    end
  endtask

  task automatic test_back_to_back();
    step();  // cycle 0
    cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h0000_0200;
    settle();
    step();  // cycle 1: ack first
    wishbone_ack_i = 1'b1; wishbone_data_i = 32'h1111_1111;
    settle();
    step();  // cycle 2: next request presented immediately
    wishbone_ack_i = 1'b0; wishbone_data_i = 32'h0; cpu_addr_i = 32'h0000_0204;
    settle();
    checks++;
    if ({stall_req_o, wishbone_cyc_o} !== 2'b10 || cpu_data_o !== 32'h1111_1111) begin
      failures++;
      $display("FAIL b2b_gap stall/cyc=%b rd=%h exp 10 rd=11111111",
               {stall_req_o, wishbone_cyc_o}, cpu_data_o);
    end
    step();  // cycle 3: second access on bus, acked
    wishbone_ack_i = 1'b1; wishbone_data_i = 32'h2222_2222;
    settle();
    checks++;
    if (wishbone_cyc_o !== 1'b1 || wishbone_addr_o !== 32'h0000_0204 || cpu_data_o !== 32'h2222_2222) begin
      failures++;
      $display("FAIL b2b_second cyc=%b addr=%h rd=%h exp 1 00000204 22222222",
               wishbone_cyc_o, wishbone_addr_o, cpu_data_o);
    end
    step();  // cycle 4
    wishbone_ack_i = 1'b0; wishbone_data_i = 32'h0; cpu_ce_i = 1'b0;
    settle();
    checks++;
    if (wishbone_cyc_o !== 1'b0 || cpu_data_o !== 32'h2222_2222) begin
      failures++;
      $display("FAIL b2b_done cyc=%b rd=%h exp 0 22222222", wishbone_cyc_o, cpu_data_o);
    end
  endtask

  task automatic test_reset_mid();
    step();  // cycle 0
    cpu_ce_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h0000_0300;
    cpu_data_i = 32'hA5A5_A5A5; cpu_sel_i = 4'b1100;
    settle();
    step();  // cycle 1: BUSY
    settle();
    checks++;
    if (wishbone_cyc_o !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_busy cyc=%b exp 1", wishbone_cyc_o);
    end
    step();  // cycle 2: reset asserted
    rst = 1'b1;
    step();  // cycle 3
    rst = 1'b0; cpu_ce_i = 1'b0; cpu_we_i = 1'b0;
    settle();
    checks++;
    if ({wishbone_cyc_o, wishbone_stb_o, wishbone_we_o, stall_req_o, bus_err_o} !== 5'b0 ||
        {wishbone_addr_o, wishbone_data_o, wishbone_sel_o, cpu_data_o} !== 100'd0) begin
      failures++;
      $display("FAIL rst_mid ctrl=%b addr=%h data=%h sel=%b rd=%h exp all zero",
               {wishbone_cyc_o, wishbone_stb_o, wishbone_we_o, stall_req_o, bus_err_o},
               wishbone_addr_o, wishbone_data_o, wishbone_sel_o, cpu_data_o);
    end
    step();  // cycle 4: stays idle with no request
    settle();
    checks++;
    if (wishbone_cyc_o !== 1'b0 || stall_req_o !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_idle cyc=%b stall=%b exp 0 0", wishbone_cyc_o, stall_req_o);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_stall_hold();
    test_timeout();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
